// File: rtl/rom_boot_pkg.sv
// Shared constants, state encoding and helpers for the boot-time ROM image loader.
package rom_boot_pkg;

    // Image span and the single gap between the PROM block and the sprite graphics
    localparam logic [16:0] IMG_START = 17'h08000;
    localparam logic [16:0] IMG_END   = 17'h17FFF;
    localparam logic [16:0] HOLE_LO   = 17'h0B61F;  // last byte before the gap
    localparam logic [16:0] HOLE_HI   = 17'h10000;  // first byte after the gap

    // Region bounds (inclusive) in image address space
    localparam logic [16:0] SUB_BASE   = 17'h08000, SUB_LIMIT   = 17'h09FFF;
    localparam logic [16:0] BG_BASE    = 17'h0A000, BG_LIMIT    = 17'h0AFFF;
    localparam logic [16:0] SCLUT_BASE = 17'h0B000, SCLUT_LIMIT = 17'h0B3FF;
    localparam logic [16:0] TCLUT_BASE = 17'h0B400, TCLUT_LIMIT = 17'h0B4FF;
    localparam logic [16:0] WAVE_BASE  = 17'h0B500, WAVE_LIMIT  = 17'h0B5FF;
    localparam logic [16:0] PAL_BASE   = 17'h0B600, PAL_LIMIT   = 17'h0B61F;
    localparam logic [16:0] SPRA_BASE  = 17'h10000, SPRA_LIMIT  = 17'h13FFF;
    localparam logic [16:0] SPRB_BASE  = 17'h14000, SPRB_LIMIT  = 17'h17FFF;

    // dl_we bit positions, one per target BRAM
    localparam int WE_SUB   = 0;
    localparam int WE_BG    = 1;
    localparam int WE_SCLUT = 2;
    localparam int WE_TCLUT = 3;
    localparam int WE_WAVE  = 4;
    localparam int WE_PAL   = 5;
    localparam int WE_SPRA  = 6;
    localparam int WE_SPRB  = 7;

    typedef enum logic [2:0] {
        ST_LOAD_ADDR,
        ST_LOAD_WAIT,
        ST_LOAD_WR,
        ST_NEXT,
        ST_DONE
    } state_t;

    function automatic logic in_range(input logic [16:0] a,
                                      input logic [16:0] lo,
                                      input logic [16:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/rom_region_dec.sv
// Maps an image address to the one-hot BRAM write strobe and flags the final byte.
module rom_region_dec
    import rom_boot_pkg::*;
(
    input  logic [16:0] addr_i,
    output logic [7:0]  we_o,
    output logic        last_o
);

    // Regions never overlap, so at most one bit can be set
    always_comb begin
        // NOTE: every bit gets a default before the range tests so no latch is inferred.
        we_o           = '0;
        we_o[WE_SUB]   = in_range(addr_i, SUB_BASE,   SUB_LIMIT);
        we_o[WE_BG]    = in_range(addr_i, BG_BASE,    BG_LIMIT);
        we_o[WE_SCLUT] = in_range(addr_i, SCLUT_BASE, SCLUT_LIMIT);
        we_o[WE_TCLUT] = in_range(addr_i, TCLUT_BASE, TCLUT_LIMIT);
        we_o[WE_WAVE]  = in_range(addr_i, WAVE_BASE,  WAVE_LIMIT);
        we_o[WE_PAL]   = in_range(addr_i, PAL_BASE,   PAL_LIMIT);
        we_o[WE_SPRA]  = in_range(addr_i, SPRA_BASE,  SPRA_LIMIT);
        we_o[WE_SPRB]  = in_range(addr_i, SPRB_BASE,  SPRB_LIMIT);
    end

    assign last_o = (addr_i == IMG_END);

endmodule

// File: rtl/rom_boot_loader.sv
// Boot sequencer: copies the external ROM image into the on-chip BRAMs one byte at a
// time, then hands the external address bus to the main CPU and releases the CPUs.
module rom_boot_loader
    import rom_boot_pkg::*;
#(
    parameter int WAIT_CYC = 2,  // ROM latency, address to valid data, 1..7
    parameter int BANK_W   = 2
) (
    input  logic                clk_6144,
    input  logic                reset,
    input  logic [BANK_W-1:0]   game_bank,
    input  logic                reload_req,
    input  logic [14:0]         cpu_ra,
    input  logic [7:0]          rom_d,
    output logic [BANK_W+16:0]  rom_a,
    output logic [16:0]         dl_addr,
    output logic [7:0]          dl_data,
    output logic [7:0]          dl_we,
    output logic                busy,
    output logic                done
);

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYC - 1);

    state_t              state_q;
    logic [BANK_W-1:0]   bank_q;
    logic [BANK_W+16:0]  rom_a_q;
    logic [16:0]         dl_addr_q;
    logic [7:0]          dl_data_q;
    logic [7:0]          dl_we_q;
    logic [2:0]          wait_q;
    logic                busy_q;
    logic                done_q;

    logic [7:0]          region_we;
    logic                region_last;
    logic [16:0]         dl_addr_d;

    rom_region_dec u_dec (
        .addr_i (dl_addr_q),
        .we_o   (region_we),
        .last_o (region_last)
    );

    // Next image address: jump the gap between the PROM block and the sprite graphics
    always_comb begin
        dl_addr_d = (dl_addr_q == HOLE_LO) ? HOLE_HI : dl_addr_q + 17'd1;
    end

    // Load FSM with registered outputs; NEXT also issues the following ROM address so
    // every byte costs WAIT_CYC+2 cycles and LOAD_ADDR only runs at the start of a pass.
    always_ff @(posedge clk_6144 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_LOAD_ADDR;
            bank_q    <= '0;
            rom_a_q   <= '0;
            dl_addr_q <= IMG_START;
            dl_data_q <= '0;
            dl_we_q   <= '0;
            wait_q    <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; the strobe defaults low and is raised only
            // on entry to LOAD_WR, which keeps it one cycle wide and never multi-hot.
            dl_we_q <= '0;
            unique case (state_q)
                ST_LOAD_ADDR: begin
                    bank_q  <= game_bank;
                    rom_a_q <= {game_bank, dl_addr_q};
                    wait_q  <= '0;
                    state_q <= ST_LOAD_WAIT;
                end
                ST_LOAD_WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        dl_data_q <= rom_d;
                        dl_we_q   <= region_we;
                        state_q   <= ST_LOAD_WR;
                    end else begin
                        wait_q <= wait_q + 3'd1;
                    end
                end
                ST_LOAD_WR: begin
                    state_q <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (region_last) begin
                        dl_addr_q <= IMG_START;
                        rom_a_q   <= {bank_q, 2'b00, cpu_ra};
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        dl_addr_q <= dl_addr_d;
                        rom_a_q   <= {bank_q, dl_addr_d};
                        wait_q    <= '0;
                        state_q   <= ST_LOAD_WAIT;
                    end
                end
                ST_DONE: begin
                    rom_a_q <= {bank_q, 2'b00, cpu_ra};
                    if (reload_req) begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= ST_LOAD_ADDR;
                    end
                end
                default: begin
                    state_q <= ST_LOAD_ADDR;
                end
            endcase
        end
    end

    assign rom_a   = rom_a_q;
    assign dl_addr = dl_addr_q;
    assign dl_data = dl_data_q;
    assign dl_we   = dl_we_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Self-checking bench for rom_boot_loader: latency-modelled ROM, expected write list
// built from the region map, and a BRAM scoreboard filled from the write strobes.
module tb_rom_boot_loader;

    localparam int W       = 1;
    localparam int N_BYTES = 46624;

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  we;
    } wr_t;

    logic        clk_6144 = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  game_bank = 2'b00;
    logic        reload_req = 1'b0;
    logic [14:0] cpu_ra = '0;
    logic [7:0]  rom_d = '0;
    logic [18:0] rom_a;
    logic [16:0] dl_addr;
    logic [7:0]  dl_data;
    logic [7:0]  dl_we;
    logic        busy;
    logic        done;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rom_mode = 1'b0;
    wr_t  exp_q[$];
    logic [7:0] mem [0:131071];

    rom_boot_loader #(.WAIT_CYC(W), .BANK_W(2)) dut (
        .clk_6144   (clk_6144),
        .reset      (reset),
        .game_bank  (game_bank),
        .reload_req (reload_req),
        .cpu_ra     (cpu_ra),
        .rom_d      (rom_d),
        .rom_a      (rom_a),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .dl_we      (dl_we),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_6144 = ~clk_6144;

    always @(posedge clk_6144) cyc++;

    // ROM contents: mode 0 returns the low address byte, mode 1 a bank-dependent hash
    function automatic logic [7:0] rom_byte(input bit mode, input logic [18:0] a);
        if (mode) return a[7:0] ^ {a[15:9], a[16]} ^ {3'b000, a[18:17], 3'b101};
        return a[7:0];
    endfunction

    // Region map as a lookup: returns the one-hot strobe, zero when not loaded
    function automatic logic [7:0] region_we(input logic [16:0] a);
        if (a >= 17'h08000 && a <= 17'h09FFF) return 8'h01;
        if (a >= 17'h0A000 && a <= 17'h0AFFF) return 8'h02;
        if (a >= 17'h0B000 && a <= 17'h0B3FF) return 8'h04;
        if (a >= 17'h0B400 && a <= 17'h0B4FF) return 8'h08;
        if (a >= 17'h0B500 && a <= 17'h0B5FF) return 8'h10;
        if (a >= 17'h0B600 && a <= 17'h0B61F) return 8'h20;
        if (a >= 17'h10000 && a <= 17'h13FFF) return 8'h40;
        if (a >= 17'h14000 && a <= 17'h17FFF) return 8'h80;
        return 8'h00;
    endfunction

    // ROM with WAIT_CYC latency: data is wrong until the address has been stable long enough
    logic [18:0] last_a = '1;
    int          age = 0;
    always @(negedge clk_6144) begin
        if (rom_a !== last_a) begin
            last_a = rom_a;
            age    = 0;
        end else begin
            age++;
        end
        rom_d = (age >= W - 1) ? rom_byte(rom_mode, rom_a) : ~rom_byte(rom_mode, rom_a);
    end

    // BRAM scoreboard
    always @(negedge clk_6144) begin
        if (!reset && dl_we != 8'h00) mem[dl_addr] = dl_data;
    end

    task automatic build_expected();
        wr_t w;
        for (int a = 0; a < 131072; a++) begin
            w.addr = 17'(a);
            w.we   = region_we(17'(a));
            if (w.we != 8'h00) exp_q.push_back(w);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_6144);
        checks++; if (dl_we !== 8'h00) begin errors++; $display("FAIL reset_we got %h want 00", dl_we); end
        checks++; if (dl_addr !== 17'h08000) begin errors++; $display("FAIL reset_addr got %h want 08000", dl_addr); end
        checks++; if (dl_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", dl_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    endtask

    task automatic test_first_bytes();
        int          rel0;
        int          n;
        int          s_cyc [3];
        logic [7:0]  s_we  [3];
        logic [16:0] s_addr[3];
        logic [7:0]  s_data[3];
        rom_mode  = 1'b0;
        game_bank = 2'b00;
        @(negedge clk_6144);
        reset = 1'b0;
        rel0  = cyc;
        n     = 0;
        for (int k = 0; k < 200 && n < 3; k++) begin
            @(negedge clk_6144);
            if (dl_we != 8'h00) begin
                s_cyc[n] = cyc; s_we[n] = dl_we; s_addr[n] = dl_addr; s_data[n] = dl_data;
                n++;
            end
        end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL first_strobes got %0d strobes want 3", n);
        end else begin
            checks++; if (s_cyc[0] - rel0 != W + 1) begin errors++; $display("FAIL first_latency got %0d want %0d", s_cyc[0] - rel0, W + 1); end
            checks++; if (s_we[0] !== 8'h01) begin errors++; $display("FAIL first_we got %h want 01", s_we[0]); end
            checks++; if (s_addr[0] !== 17'h08000) begin errors++; $display("FAIL first_addr got %h want 08000", s_addr[0]); end
            checks++; if (s_data[0] !== 8'h00) begin errors++; $display("FAIL first_data got %h want 00", s_data[0]); end
            checks++; if (s_cyc[1] - s_cyc[0] != W + 2) begin errors++; $display("FAIL strobe_period got %0d want %0d", s_cyc[1] - s_cyc[0], W + 2); end
            checks++; if (s_addr[1] !== 17'h08001 || s_data[1] !== 8'h01) begin errors++; $display("FAIL second_byte got %h/%h want 08001/01", s_addr[1], s_data[1]); end
            checks++; if (s_addr[2] !== 17'h08002 || s_cyc[2] - s_cyc[1] != W + 2) begin errors++; $display("FAIL third_byte got %h gap %0d want 08002 gap %0d", s_addr[2], s_cyc[2] - s_cyc[1], W + 2); end
        end
    endtask

    task automatic test_reset_mid_load();
        bit found = 1'b0;
        for (int k = 0; k < 40000 && !found; k++) begin
            @(negedge clk_6144);
            if (dl_we != 8'h00 && dl_addr == 17'h0A123) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL reach_0A123 timeout, strobe at 0A123 never seen");
        end else begin
            checks++; if (dl_we !== 8'h02) begin errors++; $display("FAIL bg_we got %h want 02", dl_we); end
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (dl_we !== 8'h00) begin errors++; $display("FAIL async_we got %h want 00", dl_we); end
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL async_flags got done=%b busy=%b want 0/1", done, busy); end
        checks++; if (dl_addr !== 17'h08000 || dl_data !== 8'h00) begin errors++; $display("FAIL async_addr got %h/%h want 08000/00", dl_addr, dl_data); end
        rom_mode  = 1'b1;
        game_bank = 2'b10;
        repeat (2) @(negedge clk_6144);
    endtask

    task automatic test_full_load();
        int          rel0, prev, idx, done_cyc, hole_chk_cyc;
        int          seq_bad, gap_bad, bank_bad, hole_hits, sb_bad;
        logic [16:0] last_addr, prev_addr;
        logic [7:0]  last_we;
        logic [18:0] rom_a_at_done;
        logic [14:0] ra;
        seq_bad = 0; gap_bad = 0; bank_bad = 0; hole_hits = 0; sb_bad = 0;
        idx = 0; hole_chk_cyc = -1; last_addr = '0; prev_addr = '0; last_we = '0;
        cpu_ra = 15'h1234;
        @(negedge clk_6144);
        reset = 1'b0;
        rel0  = cyc;
        prev  = rel0 - 1;
        for (int k = 0; k < 200000 && !done; k++) begin
            @(negedge clk_6144);
            if (busy && rom_a[18:17] !== 2'b10) bank_bad++;
            if ($urandom_range(0, 999) == 0) game_bank = 2'($urandom);
            reload_req = busy && ($urandom_range(0, 2999) == 0);
            if (cyc == hole_chk_cyc) begin
                checks++;
                if (rom_a !== {2'b10, 17'h10000}) begin errors++; $display("FAIL hole_rom_a got %h want %h", rom_a, {2'b10, 17'h10000}); end
            end
            if (dl_we != 8'h00) begin
                if (dl_addr >= 17'h0B620 && dl_addr < 17'h10000) hole_hits++;
                if (idx >= exp_q.size() || dl_addr !== exp_q[idx].addr || dl_we !== exp_q[idx].we ||
                    dl_data !== rom_byte(1'b1, {2'b10, dl_addr})) seq_bad++;
                if (cyc - prev != W + 2) gap_bad++;
                if (dl_addr == 17'h0B61F) begin
                    hole_chk_cyc = cyc + 2;
                    checks++;
                    if (dl_we !== 8'h20) begin errors++; $display("FAIL pal_we got %h want 20", dl_we); end
                end
                if (prev_addr == 17'h0B61F) begin
                    checks++;
                    if (dl_addr !== 17'h10000 || dl_we !== 8'h40) begin errors++; $display("FAIL after_hole got %h/%h want 10000/40", dl_addr, dl_we); end
                end
                prev      = cyc;
                prev_addr = dl_addr;
                last_addr = dl_addr;
                last_we   = dl_we;
                idx++;
            end
        end
        reload_req    = 1'b0;
        done_cyc      = cyc - rel0;
        rom_a_at_done = rom_a;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL load_timeout done=%b after %0d cycles want 1", done, done_cyc); end
        checks++; if (done_cyc != N_BYTES * (W + 2) + 1) begin errors++; $display("FAIL load_time got %0d want %0d", done_cyc, N_BYTES * (W + 2) + 1); end
        checks++; if (idx != N_BYTES) begin errors++; $display("FAIL byte_count got %0d want %0d", idx, N_BYTES); end
        checks++; if (seq_bad != 0) begin errors++; $display("FAIL write_sequence got %0d bad strobes want 0", seq_bad); end
        checks++; if (gap_bad != 0) begin errors++; $display("FAIL strobe_spacing got %0d bad gaps want 0", gap_bad); end
        checks++; if (bank_bad != 0) begin errors++; $display("FAIL load_bank got %0d cycles off bank 10 want 0", bank_bad); end
        checks++; if (hole_hits != 0) begin errors++; $display("FAIL hole_writes got %0d want 0", hole_hits); end
        checks++; if (last_addr !== 17'h17FFF || last_we !== 8'h80) begin errors++; $display("FAIL last_write got %h/%h want 17FFF/80", last_addr, last_we); end
        checks++; if (rom_a_at_done !== 19'h41234) begin errors++; $display("FAIL cpu_path_at_done got %h want 41234", rom_a_at_done); end
        checks++; if (busy !== 1'b0 || dl_we !== 8'h00 || dl_addr !== 17'h08000) begin errors++; $display("FAIL done_outputs got busy=%b we=%h addr=%h want 0/00/08000", busy, dl_we, dl_addr); end
        ra     = 15'($urandom);
        cpu_ra = ra;
        @(negedge clk_6144);
        checks++; if (rom_a !== {2'b10, 2'b00, ra}) begin errors++; $display("FAIL cpu_path got %h want %h", rom_a, {2'b10, 2'b00, ra}); end
        foreach (exp_q[i]) begin
            if (mem[exp_q[i].addr] !== rom_byte(1'b1, {2'b10, exp_q[i].addr})) sb_bad++;
        end
        checks++; if (sb_bad != 0) begin errors++; $display("FAIL bram_image got %0d wrong bytes want 0", sb_bad); end
    endtask

    task automatic test_reload();
        int  r;
        bit  found;
        game_bank  = 2'b01;
        reload_req = 1'b1;
        @(negedge clk_6144);
        r          = cyc;
        reload_req = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL reload_flags got done=%b busy=%b want 0/1", done, busy); end
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk_6144);
            if (dl_we != 8'h00) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL reload_timeout no strobe after reload");
        end else begin
            checks++; if (cyc - r != W + 1) begin errors++; $display("FAIL reload_latency got %0d want %0d", cyc - r, W + 1); end
            checks++; if (dl_addr !== 17'h08000 || dl_we !== 8'h01) begin errors++; $display("FAIL reload_first got %h/%h want 08000/01", dl_addr, dl_we); end
            checks++; if (dl_data !== rom_byte(1'b1, {2'b01, 17'h08000}) || rom_a[18:17] !== 2'b01) begin errors++; $display("FAIL reload_bank got data %h bank %b want %h/01", dl_data, rom_a[18:17], rom_byte(1'b1, {2'b01, 17'h08000})); end
        end
        // A request while busy must neither restart nor re-bank the load
        game_bank  = 2'b11;
        reload_req = 1'b1;
        @(negedge clk_6144);
        reload_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk_6144);
            if (dl_we != 8'h00) found = 1'b1;
        end
        checks++;
        if (!found || dl_addr !== 17'h08001 || dl_data !== rom_byte(1'b1, {2'b01, 17'h08001})) begin
            errors++; $display("FAIL busy_reload got %h/%h want 08001/%h", dl_addr, dl_data, rom_byte(1'b1, {2'b01, 17'h08001}));
        end
    endtask

    initial begin
        build_expected();
        test_reset();
        test_first_bytes();
        test_reset_mid_load();
        test_full_load();
        test_reload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
